// File: rtl/lgn_pkg.sv
// rtl/lgn_pkg.sv - shared constants and encodings for the LGN input loader
package lgn_pkg;

    localparam int INPUTS       = 256;
    localparam int BYTE_W       = 8;
    localparam int CNT_W        = 9;
    localparam int PACKED_BYTES = INPUTS / BYTE_W;
    localparam int GRAY_BYTES   = INPUTS;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    typedef enum logic {
        MODE_PACKED = 1'b0,
        MODE_GRAY   = 1'b1
    } mode_t;

endpackage

// File: rtl/lgn_pixel_binarizer.sv
// rtl/lgn_pixel_binarizer.sv - grayscale pixel to one bit, unsigned compare against threshold
module lgn_pixel_binarizer #(
    parameter int BYTE_W = 8
) (
    input  logic [BYTE_W-1:0] pixel,
    input  logic [BYTE_W-1:0] threshold,
    output logic              bit_out
);

    assign bit_out = (pixel >= threshold);

endmodule

// File: rtl/lgn_input_loader.sv
// rtl/lgn_input_loader.sv - byte-serial image assembler feeding the logic-gate network
module lgn_input_loader #(
    parameter int INPUTS = lgn_pkg::INPUTS,
    parameter int BYTE_W = lgn_pkg::BYTE_W,
    parameter int CNT_W  = lgn_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              frame_start,
    input  logic              mode,
    input  logic [BYTE_W-1:0] threshold,
    output logic [INPUTS-1:0] x_out,
    output logic              x_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  fill_count,
    output logic              overflow
);

    import lgn_pkg::*;

    localparam logic [CNT_W-1:0] PACKED_LAST = CNT_W'(INPUTS / BYTE_W - 1);
    localparam logic [CNT_W-1:0] GRAY_LAST   = CNT_W'(INPUTS - 1);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d, eff_mode;
    logic [INPUTS-1:0]  x_q, x_d, base_x, shifted;
    logic [CNT_W-1:0]   cnt_q, cnt_d, base_cnt, last_idx;
    logic               ovf_q, ovf_d;
    logic               pix_bit;

    lgn_pixel_binarizer #(
        .BYTE_W (BYTE_W)
    ) u_binarizer (
        .pixel     (wr_data),
        .threshold (threshold),
        .bit_out   (pix_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            mode_q  <= MODE_PACKED;
            x_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign last_idx = (mode_q == MODE_GRAY) ? GRAY_LAST : PACKED_LAST;

    // A byte arriving with frame_start shifts into a cleared image, so the
    // shift source and mode are taken from the fresh-frame values in that case.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        base_x   = x_q;
        base_cnt = cnt_q;
        eff_mode = mode_q;

        if (frame_start) begin
            base_x   = '0;
            base_cnt = '0;
            eff_mode = mode_t'(mode);
            state_d  = LOAD;
            mode_d   = mode_t'(mode);
            x_d      = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end

        if (eff_mode == MODE_GRAY) begin
            shifted = {base_x[INPUTS-2:0], pix_bit};
        end else begin
            shifted = {base_x[INPUTS-BYTE_W-1:0], wr_data};
        end

        if (wr_en) begin
            if (frame_start || state_q == LOAD) begin
                x_d   = shifted;
                cnt_d = base_cnt + CNT_W'(1);
                if (!frame_start && cnt_q == last_idx) begin
                    state_d = DONE;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign x_out      = x_q;
    assign x_valid    = (state_q == DONE);
    assign busy       = (state_q == LOAD) && (cnt_q != '0);
    assign fill_count = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_lgn_input_loader.sv
// tb/tb_lgn_input_loader.sv - directed self-checking bench for lgn_input_loader
module tb_lgn_input_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         frame_start = 1'b0;
    logic         mode = 1'b0;
    logic [7:0]   threshold = 8'h80;
    logic [255:0] x_out;
    logic         x_valid;
    logic         busy;
    logic [8:0]   fill_count;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [255:0] exp_x;
    logic [255:0] saved_x;

    always #5 clk = ~clk;

    lgn_input_loader #(
        .INPUTS (256),
        .BYTE_W (8),
        .CNT_W  (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .mode        (mode),
        .threshold   (threshold),
        .x_out       (x_out),
        .x_valid     (x_valid),
        .busy        (busy),
        .fill_count  (fill_count),
        .overflow    (overflow)
    );

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en       = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic start_frame(input logic m);
        @(negedge clk);
        wr_en       = 1'b0;
        frame_start = 1'b1;
        mode        = m;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic v, input logic b,
                              input logic [8:0] fc, input logic ov);
        chk_eq({tag, "_valid"}, 256'(x_valid), 256'(v));
        chk_eq({tag, "_busy"}, 256'(busy), 256'(b));
        chk_eq({tag, "_fill"}, 256'(fill_count), 256'(fc));
        chk_eq({tag, "_ovf"}, 256'(overflow), 256'(ov));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("rst_x", x_out, 256'h0);
        chk_status("rst", 1'b0, 1'b0, 9'd0, 1'b0);
        rst_n = 1'b1;

        // T1 packed frame 0x00..0x1F with a hold cycle before the last byte
        exp_x = '0;
        for (int i = 0; i < 31; i++) begin
            send(8'(i));
            exp_x = {exp_x[247:0], 8'(i)};
        end
        idle();
        chk_status("t1_31", 1'b0, 1'b1, 9'd31, 1'b0);
        repeat (2) @(negedge clk);
        chk_eq("t1_hold_fill", 256'(fill_count), 256'd31);
        send(8'h1F);
        exp_x = {exp_x[247:0], 8'h1F};
        idle();
        chk_eq("t1_x", x_out, exp_x);
        chk_eq("t1_msb", 256'(x_out[255:248]), 256'h00);
        chk_eq("t1_lsb", 256'(x_out[7:0]), 256'h1F);
        chk_status("t1_done", 1'b1, 1'b0, 9'd32, 1'b0);

        // T3 overflow, then frame_start clears it
        send(8'hFF);
        idle();
        chk_eq("t3_x", x_out, exp_x);
        chk_status("t3_ovf", 1'b1, 1'b0, 9'd32, 1'b1);
        start_frame(1'b1);
        chk_eq("t3_clr_x", x_out, 256'h0);
        chk_status("t3_clr", 1'b0, 1'b0, 9'd0, 1'b0);

        // T2 grayscale alternating 0x7F/0x80 at threshold 0x80; mode wiggle ignored
        threshold = 8'h80;
        for (int i = 0; i < 255; i++) begin
            send((i % 2 == 0) ? 8'h7F : 8'h80);
            if (i == 100) mode = 1'b0;
        end
        idle();
        chk_status("t2_255", 1'b0, 1'b1, 9'd255, 1'b0);
        send(8'h80);
        idle();
        chk_eq("t2_x", x_out, {32{8'h55}});
        chk_status("t2_done", 1'b1, 1'b0, 9'd256, 1'b0);

        // threshold 0 and mid-frame threshold change
        start_frame(1'b1);
        threshold = 8'h00;
        for (int i = 0; i < 4; i++) send(8'h00);
        @(negedge clk);
        wr_en     = 1'b1;
        threshold = 8'hFF;
        wr_data   = 8'hFE;
        send(8'hFF);
        idle();
        chk_eq("thr_x", x_out, 256'h3D);
        chk_status("thr", 1'b0, 1'b1, 9'd6, 1'b0);

        // T4 abort after 10 packed bytes, then a full frame
        start_frame(1'b0);
        for (int i = 0; i < 10; i++) send(8'hE0 + 8'(i));
        idle();
        chk_status("t4_10", 1'b0, 1'b1, 9'd10, 1'b0);
        start_frame(1'b0);
        chk_eq("t4_abort_x", x_out, 256'h0);
        chk_status("t4_abort", 1'b0, 1'b0, 9'd0, 1'b0);
        exp_x = '0;
        for (int i = 0; i < 32; i++) begin
            send(8'(i) ^ 8'h5A);
            exp_x = {exp_x[247:0], 8'(i) ^ 8'h5A};
        end
        idle();
        chk_eq("t4_x", x_out, exp_x);
        chk_status("t4_done", 1'b1, 1'b0, 9'd32, 1'b0);
        saved_x = x_out;

        // T5 frame_start with a byte while DONE
        @(negedge clk);
        frame_start = 1'b1;
        mode        = 1'b0;
        wr_en       = 1'b1;
        wr_data     = 8'hA5;
        idle();
        chk_eq("t5_x", x_out, 256'hA5);
        chk_status("t5", 1'b0, 1'b1, 9'd1, 1'b0);

        // T6 async reset mid-frame between edges; mode_q returns to packed
        start_frame(1'b1);
        threshold = 8'h00;
        for (int i = 0; i < 17; i++) send(8'h11);
        idle();
        chk_eq("t6_pre_fill", 256'(fill_count), 256'd17);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_x", x_out, 256'h0);
        chk_status("t6_rst", 1'b0, 1'b0, 9'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_x = '0;
        for (int i = 0; i < 32; i++) begin
            send(8'hC3 - 8'(i));
            exp_x = {exp_x[247:0], 8'hC3 - 8'(i)};
        end
        idle();
        chk_eq("t6_x", x_out, exp_x);
        chk_status("t6_done", 1'b1, 1'b0, 9'd32, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
